// File: rtl/game_pkg.sv
// Shared types for the player input path: shoot FSM states, direction indices
// and the direction arbiter used by each player.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        FIRE         = 2'd1,
        COOLDOWN     = 2'd2,
        WAIT_RELEASE = 2'd3
    } shoot_state_t;

    localparam int DIR_DOWN  = 0;
    localparam int DIR_UP    = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Keeps the current direction while it is still held, so a second button
    // never steals the output mid-move; otherwise fixed up > down > left > right.
    function automatic logic [3:0] dir_arb(input logic [3:0] i_btn, input logic [3:0] i_cur);
        logic [3:0] w_res;
        w_res = 4'b0000;
        if ($countones(i_btn) <= 1)
            w_res = i_btn;
        else if ((i_btn & i_cur) != 4'b0000)
            w_res = i_cur;
        else if (i_btn[DIR_UP])
            w_res[DIR_UP] = 1'b1;
        else if (i_btn[DIR_DOWN])
            w_res[DIR_DOWN] = 1'b1;
        else if (i_btn[DIR_LEFT])
            w_res[DIR_LEFT] = 1'b1;
        else
            w_res[DIR_RIGHT] = 1'b1;
        return w_res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchroniser followed by a hold-time filter.
// stable_o follows the raw input 2 + DEBOUNCE_CYCLES edges after a clean edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 24
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= raw_i;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == L_LAST) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable_o = r_stable;

endmodule

// File: rtl/player_input_cond.sv
// Debounces all ten player buttons, arbitrates each player's moves to one-hot
// and turns each shoot button into a fixed-width, rate-limited fire pulse.
module player_input_cond
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int PULSE_CYCLES    = 4,
    parameter int COOLDOWN_CYCLES = 12_500_000,
    parameter int CNT_W           = 24
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] p1_move_raw_i,
    input  logic       p1_shoot_raw_i,
    input  logic [3:0] p2_move_raw_i,
    input  logic       p2_shoot_raw_i,
    output logic [3:0] player_1_move_o,
    output logic       player_1_shoot_o,
    output logic [3:0] player_2_move_o,
    output logic       player_2_shoot_o
);

    localparam logic [CNT_W-1:0] L_PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_COOL_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [3:0] w_move_raw [2];
    logic [1:0] w_shoot_raw;
    logic [3:0] w_dir      [2];
    logic [1:0] w_fire;

    assign w_move_raw[0] = p1_move_raw_i;
    assign w_move_raw[1] = p2_move_raw_i;
    assign w_shoot_raw   = {p2_shoot_raw_i, p1_shoot_raw_i};

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic [3:0]       w_move_stable;
        logic             w_shoot_stable;
        logic [3:0]       r_dir;
        logic             r_fire;
        shoot_state_t     r_state;
        logic [CNT_W-1:0] r_cnt;

        for (genvar b = 0; b < 4; b++) begin : g_move_db
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .raw_i   (w_move_raw[p][b]),
                .stable_o(w_move_stable[b])
            );
        end

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_shoot_db (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (w_shoot_raw[p]),
            .stable_o(w_shoot_stable)
        );

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)
                r_dir <= 4'b0000;
            else
                r_dir <= dir_arb(w_move_stable, r_dir);
        end

        // A press seen in FIRE or COOLDOWN is dropped; only a fresh press from IDLE fires.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_state <= IDLE;
                r_fire  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_shoot_stable) begin
                            r_state <= FIRE;
                            r_fire  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end
                    FIRE: begin
                        if (r_cnt == L_PULSE_LAST) begin
                            r_state <= COOLDOWN;
                            r_fire  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    COOLDOWN: begin
                        if (r_cnt == L_COOL_LAST) begin
                            r_cnt   <= '0;
                            r_state <= w_shoot_stable ? WAIT_RELEASE : IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!w_shoot_stable)
                            r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_fire  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_dir[p]  = r_dir;
        assign w_fire[p] = r_fire;
    end

    assign player_1_move_o  = w_dir[0];
    assign player_2_move_o  = w_dir[1];
    assign player_1_shoot_o = w_fire[0];
    assign player_2_shoot_o = w_fire[1];

endmodule
